// File: rtl/accu_stream.sv
`default_nettype none
// ============================================================================
// Module      : accu_stream
// Description : Streaming accumulator that sums groups of NUM beats with
//               valid/ready on both sides. Define ACCU_FLUSH_EN to add the
//               partial-group flush port.
// Revision    : 1.0 - initial release
// ============================================================================
module accu_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM    = 4,
    parameter int unsigned OUT_W  = DATA_W + $clog2(NUM),
    parameter int unsigned CNT_W  = $clog2(NUM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ACCU_FLUSH_EN
    input  logic              flush,
`endif
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [OUT_W-1:0]  data_out,
    output logic [CNT_W-1:0]  data_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(NUM - 1);
    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(NUM);

    logic [OUT_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [OUT_W-1:0] dout_q,  dout_d;
    logic [CNT_W-1:0] dcnt_q,  dcnt_d;
    logic             vout_q,  vout_d;

    logic             w_slot_free;
    logic             w_last;
    logic             w_accept;
    logic [OUT_W-1:0] w_din_ext;
    logic [OUT_W-1:0] w_sum;

    assign w_slot_free = !vout_q || ready_out;
    assign w_last      = (cnt_q == c_CNT_LAST);
    assign w_din_ext   = OUT_W'(data_in);
    assign w_sum       = acc_q + w_din_ext;
    assign w_accept    = valid_in && ready_in;

`ifdef ACCU_FLUSH_EN
    logic fpend_q, fpend_d;
    logic w_flush_fire;

    // The pending flush blocks input, so it never competes with a beat.
    assign w_flush_fire = fpend_q && w_slot_free;
    assign ready_in     = !fpend_q && (!w_last || w_slot_free);
`else
    assign ready_in     = !w_last || w_slot_free;
`endif

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        dcnt_d = dcnt_q;
        vout_d = vout_q;

        if (vout_q && ready_out) begin
            vout_d = 1'b0;
        end

        if (w_accept) begin
            if (cnt_q == '0) begin
                acc_d = w_din_ext;
                cnt_d = CNT_W'(1);
            end else if (w_last) begin
                // A load in the consume cycle overrides the clear above.
                dout_d = w_sum;
                dcnt_d = c_CNT_FULL;
                vout_d = 1'b1;
                cnt_d  = '0;
            end else begin
                acc_d = w_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

`ifdef ACCU_FLUSH_EN
        fpend_d = fpend_q;
        if (flush && !fpend_q) begin
            fpend_d = 1'b1;
        end
        if (w_flush_fire) begin
            fpend_d = 1'b0;
            if (cnt_q != '0) begin
                dout_d = acc_q;
                dcnt_d = cnt_q;
                vout_d = 1'b1;
                cnt_d  = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            dcnt_q <= '0;
            vout_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            dcnt_q <= dcnt_d;
            vout_q <= vout_d;
        end
    end

`ifdef ACCU_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpend_q <= 1'b0;
        end else begin
            fpend_q <= fpend_d;
        end
    end
`endif

    assign valid_out = vout_q;
    assign data_out  = dout_q;
    assign data_cnt  = dcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_accu_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_accu_stream
// Description : Directed self-checking bench for accu_stream (8x4 and 16x8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accu_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic [7:0]  a_din = '0;
    logic        a_vin = 1'b0;
    logic        a_rin;
    logic        a_vout;
    logic        a_rout = 1'b1;
    logic [9:0]  a_dout;
    logic [2:0]  a_dcnt;

    logic [15:0] b_din = '0;
    logic        b_vin = 1'b0;
    logic        b_rin;
    logic        b_vout;
    logic        b_rout = 1'b1;
    logic [18:0] b_dout;
    logic [3:0]  b_dcnt;

    int n_pass  = 0;
    int n_check = 0;
    int n_stall = 0;
    logic [9:0] taken_q[$];

    always #5 clk = ~clk;

    accu_stream #(.DATA_W(8), .NUM(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ACCU_FLUSH_EN
        .flush     (flush),
`endif
        .data_in   (a_din),
        .valid_in  (a_vin),
        .ready_in  (a_rin),
        .valid_out (a_vout),
        .ready_out (a_rout),
        .data_out  (a_dout),
        .data_cnt  (a_dcnt)
    );

    accu_stream #(.DATA_W(16), .NUM(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef ACCU_FLUSH_EN
        .flush     (1'b0),
`endif
        .data_in   (b_din),
        .valid_in  (b_vin),
        .ready_in  (b_rin),
        .valid_out (b_vout),
        .ready_out (b_rout),
        .data_out  (b_dout),
        .data_cnt  (b_dcnt)
    );

    // Record every result handed downstream by DUT A.
    always @(posedge clk) begin
        if (a_vout && a_rout) taken_q.push_back(a_dout);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] v);
        int k;
        k = 0;
        a_vin = 1'b1;
        a_din = v;
        while (!a_rin && k < 50) begin
            tick();
            k++;
            n_stall++;
        end
        if (k == 50) check("beat_timeout", 32'(a_rin), 32'd1);
        tick();
        a_vin = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_vout", 32'(a_vout), 0);
        check("rst_dout", 32'(a_dout), 0);
        check("rst_dcnt", 32'(a_dcnt), 0);
        check("rst_rin",  32'(a_rin),  1);
        tick();
        rst_n = 1'b1;
        tick();

        // 1,2,3,4 -> 10
        beat(8'd1); beat(8'd2); beat(8'd3); beat(8'd4);
        check("sum10_vout", 32'(a_vout), 1);
        check("sum10_dout", 32'(a_dout), 10);
        check("sum10_dcnt", 32'(a_dcnt), 4);
        tick();
        check("sum10_consumed", 32'(a_vout), 0);
        check("sum10_hold",     32'(a_dout), 10);

        // Four beats of 255 -> 1020
        repeat (4) beat(8'd255);
        check("max_dout", 32'(a_dout), 1020);
        check("max_vout", 32'(a_vout), 1);
        tick();

        // DUT B: eight beats of 0xFFFF -> 0x7FFF8
        b_vin = 1'b1;
        b_din = 16'hFFFF;
        repeat (8) tick();
        b_vin = 1'b0;
        check("b_vout", 32'(b_vout), 1);
        check("b_dout", 32'(b_dout), 32'h7FFF8);
        check("b_dcnt", 32'(b_dcnt), 8);

        // Backpressure: 12 beats of 1 with ready_out low at first
        taken_q.delete();
        a_rout = 1'b0;
        repeat (7) beat(8'd1);
        check("bp_vout", 32'(a_vout), 1);
        check("bp_dout", 32'(a_dout), 4);
        check("bp_rin",  32'(a_rin),  0);
        a_vin = 1'b1;
        a_din = 8'd1;
        repeat (3) tick();
        check("bp_rin_held",  32'(a_rin),  0);
        check("bp_dout_held", 32'(a_dout), 4);
        check("bp_dcnt_held", 32'(a_dcnt), 4);
        check("bp_none_taken", 32'(taken_q.size()), 0);
        a_rout = 1'b1;
        #1;
        check("bp_rin_release", 32'(a_rin), 1);
        tick();
        a_vin = 1'b0;
        check("bp_no_bubble", 32'(a_vout), 1);
        repeat (4) beat(8'd1);
        tick();
        check("bp_taken_cnt", 32'(taken_q.size()), 3);
        for (int i = 0; i < 3; i++) check("bp_taken_val", 32'(taken_q[i]), 4);
        check("bp_idle_vout", 32'(a_vout), 0);

        // Continuous stream 1..12 -> 10, 26, 42
        taken_q.delete();
        n_stall = 0;
        for (int i = 1; i <= 12; i++) beat(8'(i));
        tick();
        check("cont_taken_cnt", 32'(taken_q.size()), 3);
        if (taken_q.size() == 3) begin
            check("cont_sum0", 32'(taken_q[0]), 10);
            check("cont_sum1", 32'(taken_q[1]), 26);
            check("cont_sum2", 32'(taken_q[2]), 42);
        end
        check("cont_stalls", 32'(n_stall), 0);

        // Reset mid-group discards the partial sum
        taken_q.delete();
        beat(8'd7); beat(8'd9);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vout", 32'(a_vout), 0);
        check("mid_rst_dout", 32'(a_dout), 0);
        check("mid_rst_rin",  32'(a_rin),  1);
        tick();
        rst_n = 1'b1;
        repeat (4) beat(8'd1);
        tick();
        check("mid_rst_taken_cnt", 32'(taken_q.size()), 1);
        if (taken_q.size() == 1) check("mid_rst_val", 32'(taken_q[0]), 4);

`ifdef ACCU_FLUSH_EN
        // Partial flush 5,6 -> 11 with count 2
        beat(8'd5); beat(8'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_pend_rin", 32'(a_rin),  0);
        check("fl_pend_vout", 32'(a_vout), 0);
        tick();
        check("fl_vout", 32'(a_vout), 1);
        check("fl_dout", 32'(a_dout), 11);
        check("fl_dcnt", 32'(a_dcnt), 2);
        check("fl_rin",  32'(a_rin),  1);
        tick();
        check("fl_consumed", 32'(a_vout), 0);

        // Flush with an empty group produces nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl0_rin_pend", 32'(a_rin), 0);
        tick();
        check("fl0_vout", 32'(a_vout), 0);
        check("fl0_rin",  32'(a_rin),  1);

        // Flush while a result is held
        a_rout = 1'b0;
        repeat (4) beat(8'd1);
        beat(8'd2); beat(8'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flh_rin", 32'(a_rin), 0);
        repeat (2) tick();
        check("flh_rin_held", 32'(a_rin),  0);
        check("flh_dout_held", 32'(a_dout), 4);
        check("flh_dcnt_held", 32'(a_dcnt), 4);
        a_rout = 1'b1;
        tick();
        check("flh_vout", 32'(a_vout), 1);
        check("flh_dout", 32'(a_dout), 5);
        check("flh_dcnt", 32'(a_dcnt), 2);
        tick();
        check("flh_consumed", 32'(a_vout), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
`default_nettype wire
